// File: rtl/data_mem.sv
// Word-writable, line-readable data memory with a main-memory latency model (rdy).
// Macro: DATA_MEM_WRITE_FWD_EN (write-first data register).
module data_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LAT         = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [31:0]  a,
  input  logic [31:0]  wd,
  output logic [127:0] data,
  output logic         rdy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = AW - 2;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [AW-1:0]  widx;
  logic [LW-1:0]  line;
  logic [LW-1:0]  last_line;
  logic [7:0]     cnt;
  logic [127:0]   line_rd;
  logic           unused_addr;

  assign widx        = a[AW+1:2];
  assign line        = a[AW+1:4];
  assign unused_addr = ^{a[31:AW+2], a[1:0]};

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wd;
  end

  // Write and read share one address, so a forwarded write always hits the current line.
  always_comb begin
    line_rd = {mem[{line, 2'd3}], mem[{line, 2'd2}], mem[{line, 2'd1}], mem[{line, 2'd0}]};
`ifdef DATA_MEM_WRITE_FWD_EN
    if (we) begin
      case (widx[1:0])
        2'd0:    line_rd[31:0]   = wd;
        2'd1:    line_rd[63:32]  = wd;
        2'd2:    line_rd[95:64]  = wd;
        default: line_rd[127:96] = wd;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) data <= '0;
    else       data <= line_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      last_line <= '0;
    end else if (line != last_line) begin
      last_line <= line;
      cnt       <= '0;
    end else if (cnt != 8'(LAT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign rdy = (cnt == 8'(LAT));

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus random traffic against a reference model.
module tb_data_mem;
  localparam int DEPTH = 256;
  localparam int LAT   = 10;

  logic         clk = 1'b0;
  logic         reset, we;
  logic [31:0]  a, wd;
  logic [127:0] data;
  logic         rdy;

  int checks = 0;
  int errors = 0;

  // reference model: word array, held line and the edge at which it was captured
  logic [31:0]  m_mem [DEPTH];
  logic [127:0] m_data;
  int           m_line;
  int           m_start;
  int           edge_no = 0;

  data_mem #(.DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .data(data), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
    end
  endtask

  // one clock: drive, advance model on the edge, compare 1 time unit later
  task automatic step(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] d);
    int l, wi;
    logic [127:0] line_val;
    reset = r; we = w; a = addr; wd = d;
    @(posedge clk);
    edge_no++;
    l  = int'(addr[9:4]);
    wi = int'(addr[9:2]);
    for (int k = 0; k < 4; k++) line_val[k*32 +: 32] = m_mem[l*4 + k];
`ifdef DATA_MEM_WRITE_FWD_EN
    if (w) line_val[(wi % 4)*32 +: 32] = d;
`endif
    if (r) begin
      m_data  = '0;
      m_line  = 0;
      m_start = edge_no;
    end else begin
      m_data = line_val;
      if (l != m_line) begin
        m_line  = l;
        m_start = edge_no;
      end
    end
    if (w) m_mem[wi] = d;
    #1;
    chk_word("model_data", data, m_data);
    chk_bit("model_rdy", rdy, (edge_no - m_start) >= LAT);
  endtask

  initial begin
    logic [31:0] exp_w;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_data = '0; m_line = 0; m_start = 0;

    // clear the array under reset so nothing depends on power-up contents
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 32'(i*4), 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // reset then latency from the capture of a=0x40
    step(1'b1, 1'b0, 32'h40, 32'h0);
    step(1'b1, 1'b0, 32'h40, 32'h0);
    chk_word("reset_data", data, 128'h0);
    chk_bit("reset_rdy", rdy, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h40, 32'h0);
    chk_bit("rdy_edge9", rdy, 1'b0);
    step(1'b0, 1'b0, 32'h40, 32'h0);
    chk_bit("rdy_edge10", rdy, 1'b1);

    // word writes into one line
    step(1'b0, 1'b1, 32'h40, 32'h11111111);
    step(1'b0, 1'b1, 32'h44, 32'h22222222);
    step(1'b0, 1'b1, 32'h48, 32'h33333333);
    step(1'b0, 1'b1, 32'h4C, 32'h44444444);
    step(1'b0, 1'b0, 32'h40, 32'h0);
    chk_word("line_writes", data, 128'h44444444_33333333_22222222_11111111);

    // latency restart on line change
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h80, 32'h0);
      chk_bit("restart_low", rdy, 1'b0);
    end
    step(1'b0, 1'b0, 32'h80, 32'h0);
    chk_bit("restart_high", rdy, 1'b1);
    step(1'b0, 1'b0, 32'h8C, 32'h0);
    chk_bit("in_line_move", rdy, 1'b1);

    // same-line write while reading line 0x40
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h40, 32'h0);
    step(1'b0, 1'b1, 32'h44, 32'hDEADBEEF);
`ifdef DATA_MEM_WRITE_FWD_EN
    exp_w = 32'hDEADBEEF;
`else
    exp_w = 32'h22222222;
`endif
    chk_word("same_line_first", {96'h0, data[63:32]}, {96'h0, exp_w});
    step(1'b0, 1'b0, 32'h40, 32'h0);
    chk_word("same_line_next", {96'h0, data[63:32]}, {96'h0, 32'hDEADBEEF});

    // wrap-around addressing
    step(1'b0, 1'b1, 32'(4*DEPTH), 32'hA5A5A5A5);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk_word("wrap", {96'h0, data[31:0]}, {96'h0, 32'hA5A5A5A5});

    // reset mid-count while ready
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 32'h80, 32'h0);
    chk_bit("pre_reset_rdy", rdy, 1'b1);
    step(1'b1, 1'b0, 32'h80, 32'h0);
    chk_bit("mid_reset_rdy", rdy, 1'b0);
    chk_word("mid_reset_data", data, 128'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h80, 32'h0);
    chk_bit("post_reset_low", rdy, 1'b0);
    step(1'b0, 1'b0, 32'h80, 32'h0);
    chk_bit("post_reset_high", rdy, 1'b1);

    // random traffic: a few lines, bursts of stable address, occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      int hold;
      ra   = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0,
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
      hold = $urandom_range(1, 14);
      for (int h = 0; h < hold; h++)
        step($urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0,
             {ra[31:4], 2'($urandom), ra[1:0]}, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
